// File: rtl/kernel_dispatcher.sv
// kernel_dispatcher: round-robin arbiter that shares one start/done kernel among NREQ requesters.
// Latency: accept -> kernel start pulse next cycle; kernel done -> response valid next cycle.
// Backpressure: req_ready only in IDLE; the response is held until the granted requester's rsp_ready.
// Optional kernel watchdog enabled by defining KDISP_TIMEOUT_EN.
module kernel_dispatcher #(
   parameter int NREQ    = 4,
   parameter int W       = 64,
   parameter int TIMEOUT = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*W-1:0] req_n,
   input  logic [NREQ*W-1:0] req_a,
   input  logic [NREQ*W-1:0] req_b,
   output logic [NREQ-1:0]   rsp_valid,
   input  logic [NREQ-1:0]   rsp_ready,
   output logic [W-1:0]      rsp_data,
   output logic              rsp_err,
   output logic              k_r_enable,
   output logic [W-1:0]      k_init_n,
   output logic [W-1:0]      k_init_a,
   output logic [W-1:0]      k_init_b,
   input  logic              k_w_enable,
   input  logic [W-1:0]      k_result,
   output logic              busy
);

   localparam int PW = $clog2(NREQ);

   typedef enum logic [1:0] {ST_IDLE, ST_LAUNCH, ST_WAIT, ST_RESP} state_t;

   state_t          r_state;
   logic [PW-1:0]   r_ptr;
   logic [PW-1:0]   r_gnt;
   logic [NREQ-1:0] r_rsp_vld;
   logic            r_kstart;
   logic [W-1:0]    r_init_n;
   logic [W-1:0]    r_init_a;
   logic [W-1:0]    r_init_b;
   logic [W-1:0]    r_rsp_data;

   logic [PW-1:0]   w_gnt;
   logic [PW-1:0]   w_idx;
   logic            w_gnt_vld;
   logic [NREQ-1:0] w_req_rdy;
   logic [NREQ-1:0] w_rsp_oh;
   logic [W-1:0]    w_n [NREQ];
   logic [W-1:0]    w_a [NREQ];
   logic [W-1:0]    w_b [NREQ];

`ifdef KDISP_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT) + 1;
   logic [CW-1:0]   r_wcnt;
   logic            r_rsp_err;
`else
   logic            w_unused_timeout;
   // The watchdog limit has no meaning without the watchdog.
   assign w_unused_timeout = ^TIMEOUT;
`endif

   // Split the packed operand buses into per-requester words.
   for (genvar i = 0; i < NREQ; i++) begin : g_unpack
      assign w_n[i] = req_n[i*W +: W];
      assign w_a[i] = req_a[i*W +: W];
      assign w_b[i] = req_b[i*W +: W];
   end

   // Round-robin search starting at r_ptr; walk backwards so the nearest requester wins.
   always_comb begin
      w_gnt_vld = 1'b0;
      w_gnt     = '0;
      w_idx     = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         w_idx = PW'((int'(r_ptr) + k) % NREQ);
         if (req_valid[w_idx]) begin
            w_gnt_vld = 1'b1;
            w_gnt     = w_idx;
         end
      end
   end

   // Accept only in IDLE; one-hot on the winning requester.
   always_comb begin
      w_req_rdy = '0;
      if (r_state == ST_IDLE && w_gnt_vld) begin
         w_req_rdy[w_gnt] = 1'b1;
      end
   end

   // One-hot of the latched grant, used to steer the response.
   always_comb begin
      w_rsp_oh        = '0;
      w_rsp_oh[r_gnt] = 1'b1;
   end

   // Job FSM: accept, pulse kernel start, wait for done (or watchdog), hold response.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_ptr      <= '0;
         r_gnt      <= '0;
         r_rsp_vld  <= '0;
         r_kstart   <= 1'b0;
         r_init_n   <= '0;
         r_init_a   <= '0;
         r_init_b   <= '0;
         r_rsp_data <= '0;
`ifdef KDISP_TIMEOUT_EN
         r_wcnt     <= '0;
         r_rsp_err  <= 1'b0;
`endif
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_gnt_vld) begin
                  r_gnt    <= w_gnt;
                  r_init_n <= w_n[w_gnt];
                  r_init_a <= w_a[w_gnt];
                  r_init_b <= w_b[w_gnt];
                  r_kstart <= 1'b1;
                  r_state  <= ST_LAUNCH;
               end
            end
            ST_LAUNCH: begin
               // k_w_enable may still be high from the previous job, so it is not looked at here.
               r_kstart <= 1'b0;
`ifdef KDISP_TIMEOUT_EN
               r_wcnt   <= '0;
`endif
               r_state  <= ST_WAIT;
            end
            ST_WAIT: begin
               if (k_w_enable) begin
                  r_rsp_data <= k_result;
                  r_rsp_vld  <= w_rsp_oh;
`ifdef KDISP_TIMEOUT_EN
                  r_rsp_err  <= 1'b0;
`endif
                  r_state    <= ST_RESP;
               end
`ifdef KDISP_TIMEOUT_EN
               else if (r_wcnt == CW'(TIMEOUT - 1)) begin
                  r_rsp_data <= '0;
                  r_rsp_vld  <= w_rsp_oh;
                  r_rsp_err  <= 1'b1;
                  r_state    <= ST_RESP;
               end else begin
                  r_wcnt <= r_wcnt + CW'(1);
               end
`endif
            end
            ST_RESP: begin
               if (rsp_ready[r_gnt]) begin
                  r_rsp_vld <= '0;
                  r_ptr     <= (r_gnt == PW'(NREQ - 1)) ? '0 : r_gnt + PW'(1);
                  r_state   <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign req_ready  = w_req_rdy;
   assign rsp_valid  = r_rsp_vld;
   assign rsp_data   = r_rsp_data;
   assign k_r_enable = r_kstart;
   assign k_init_n   = r_init_n;
   assign k_init_a   = r_init_a;
   assign k_init_b   = r_init_b;
   assign busy       = (r_state != ST_IDLE);
`ifdef KDISP_TIMEOUT_EN
   assign rsp_err    = r_rsp_err;
`else
   assign rsp_err    = 1'b0;
`endif

endmodule
